seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Downstream display stage for the alarm clock; drives the board's 8-digit multiplexed seven-segment display (CA..CG, DP, AN[7:0]).
- Consumes the four current-time BCD digits and the 1 Hz level produced by top_alarm, plus four alarm-time digits.
- Time-multiplexes the digits with an anti-ghosting blank gap, leading-zero suppression, per-digit blink and a seconds colon.
- All outputs are registered.

Parameters:
- DWELL_CYC, 100000: clock cycles per digit slot (1 ms at 100 MHz). Constraint: DWELL_CYC > BLANK_CYC.
- BLANK_CYC, 1000: cycles at the start of each slot during which all anodes are off. Must be ≥ 1.
- LZ_BLANK, 1: 1 = blank the hour-tens digit (digits 3 and 7) when its value is 0.

Ports:
- clk  in  1  system clock (CLK100MHZ)
- rstn  in  1  reset, synchronous, active-low
- en  in  1  display enable; 0 = all anodes off
- hourdec_now, hourone_now, mindec_now, minone_now  in  4 each  current time, BCD
- hourdec_alm, hourone_alm, mindec_alm, minone_alm  in  4 each  alarm time, BCD
- sec_level  in  1  1 Hz square wave (clk_sec_o), drives the colon
- blink_mask  in  8  bit i = 1 makes digit i blink
- blink_phase  in  1  blink phase; blinking digits are shown only while this is 1
- seg  out  7  cathodes, active-low; seg[0]=CA ... seg[6]=CG
- dp_n  out  1  decimal point, active-low
- an  out  8  anodes, active-low; an[i] selects digit i

Behaviour:
- Reset (rstn=0 at a clk edge) sets:
  - an=8'hFF, seg=7'h7F, dp_n=1
  - slot counter cnt=0, digit index idx=0
  - shadow digit registers all 0
- Digit map:
  - idx 0..3 = minone_now, mindec_now, hourone_now, hourdec_now
  - idx 4..7 = minone_alm, mindec_alm, hourone_alm, hourdec_alm
- Slot FSM, two states:
  - BLANK: cnt 0..BLANK_CYC-1.
  - DRIVE: cnt BLANK_CYC..DWELL_CYC-1.
  - cnt increments every cycle. At cnt=DWELL_CYC-1 it wraps to 0 and idx increments, 7→0.
- Output latency: outputs are registered from (state, idx) with 1-cycle latency.
  - After rstn deasserts, an[0] first goes low at rising edge BLANK_CYC+1.
  - Each an[i] is low for exactly DWELL_CYC-BLANK_CYC consecutive cycles per frame.
  - At most one an bit is low at any time; an is all-ones for BLANK_CYC cycles between consecutive digits.
- Frame shadowing:
  - All 8 digit inputs are captured into shadow registers on the cycle idx wraps 7→0 (frame start), and also on the cycle reset is released.
  - Display content is constant within a frame; no tearing.
- Slot-start sampling: blink_mask, blink_phase and sec_level are sampled at cnt=0 of each slot and held for that slot.
- Decode of the shadow value, shown as seg[6:0] (active-low):
  - 0: 1000000
  - 1: 1111001
  - 2: 0100100
  - 3: 0110000
  - 4: 0011001
  - 5: 0010010
  - 6: 0000010
  - 7: 1111000
  - 8: 0000000
  - 9: 0010000
  - 10..15: dash, 0111111
- Digit blanking (seg=7'h7F, dp_n=1, anode still driven): applied in DRIVE when any of the following holds:
  - LZ_BLANK=1, idx∈{3,7}, and the digit value is 0
  - blink_mask[idx]=1 and sampled blink_phase=0
- Colon: dp_n=0 only when idx=2, in DRIVE, and sampled sec_level=1. Otherwise dp_n=1.
- Enable:
  - en=0 forces an=8'hFF, seg=7'h7F, dp_n=1 from the next edge.
  - cnt, idx and shadowing keep running while en=0.
  - On en=1 the output resumes mid-slot at the current idx with no restart.
- Reset mid-slot: returns to the reset state at the next edge; no partial digit is extended.

Test Plan (DWELL_CYC=8, BLANK_CYC=2):
- Release reset with time 12:34, alarm 07:05 → an sequence FE, FD, FB, F7, EF, DF, BF, 7F, each low 6 cycles with FF for 2 cycles between. seg per slot: 4=0011001, 3=0110000, 2=0100100, 1=1111001, 5=0010010, 0=1000000, 7=1111000, then blank 7F (alarm hour-tens 0, LZ).
- Change minone_now 4→9 while idx=3 → digit 0 still shows 4 until the next frame, then shows 9 (0010000).
- sec_level=1 → dp_n=0 only during the 6 DRIVE cycles of idx 2; sec_level=0 → dp_n stays 1.
- blink_mask=8'h03 with blink_phase=0 → digits 0 and 1 show seg=7F while their anode is low. With blink_phase=1 → normal digits.
- hourdec_now=4'hB → digit 3 shows dash 0111111. hourdec_now=0 with LZ_BLANK=1 → 7F; with LZ_BLANK=0 → 1000000.
- Drop en for 5 cycles mid-DRIVE of idx 1 → an=FF during those cycles; on resume an=FD for the remaining slot cycles. Assert rstn=0 mid-slot → an=FF and idx restarts at 0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 8-digit multiplexed seven-segment scan driver with blank gap, LZ suppression, blink and colon
module seg7_scan_driver #(
    parameter int DWELL_CYC = 100000,
    parameter int BLANK_CYC = 1000,
    parameter int LZ_BLANK  = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic [3:0] hourdec_now,
    input  logic [3:0] hourone_now,
    input  logic [3:0] mindec_now,
    input  logic [3:0] minone_now,
    input  logic [3:0] hourdec_alm,
    input  logic [3:0] hourone_alm,
    input  logic [3:0] mindec_alm,
    input  logic [3:0] minone_alm,
    input  logic       sec_level,
    input  logic [7:0] blink_mask,
    input  logic       blink_phase,
    output logic [6:0] seg,
    output logic       dp_n,
    output logic [7:0] an
);

    localparam int CW = $clog2(DWELL_CYC);

    typedef enum logic {S_BLANK, S_DRIVE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0][3:0] shadow_q;
    logic            first_q;
    logic [7:0]      blink_q;
    logic            phase_q;
    logic            sec_q;
    logic [7:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;

    logic            last;
    logic            capture;
    logic            drive;
    logic            blank_dig;
    logic [3:0]      val;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    always_comb begin
        last    = (cnt_q == CW'(DWELL_CYC - 1));
        cnt_d   = last ? '0 : cnt_q + 1'b1;
        idx_d   = last ? idx_q + 3'd1 : idx_q;
        state_d = (cnt_d >= CW'(BLANK_CYC)) ? S_DRIVE : S_BLANK;
        // New frame content is latched on the 7->0 wrap, or on the first cycle out of reset
        capture = first_q || (last && (idx_q == 3'd7));

        val       = shadow_q[idx_q];
        blank_dig = ((LZ_BLANK != 0) && ((idx_q == 3'd3) || (idx_q == 3'd7)) && (val == 4'd0))
                    || (blink_q[idx_q] && !phase_q);
        drive     = en && (state_q == S_DRIVE);

        an_d  = drive ? ~(8'h01 << idx_q) : 8'hFF;
        seg_d = (drive && !blank_dig) ? decode(val) : 7'h7F;
        dp_d  = !(drive && !blank_dig && (idx_q == 3'd2) && sec_q);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_BLANK;
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            first_q  <= 1'b1;
            blink_q  <= '0;
            phase_q  <= 1'b0;
            sec_q    <= 1'b0;
            an_q     <= 8'hFF;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            first_q <= 1'b0;
            if (capture) begin
                shadow_q <= {hourdec_alm, hourone_alm, mindec_alm, minone_alm,
                             hourdec_now, hourone_now, mindec_now, minone_now};
            end
            if (cnt_q == '0) begin
                blink_q <= blink_mask;
                phase_q <= blink_phase;
                sec_q   <= sec_level;
            end
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp_n = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

    localparam int DW = 8;
    localparam int BL = 2;

    logic       clk = 1'b0;
    logic       rstn;
    logic       en;
    logic [3:0] hourdec_now, hourone_now, mindec_now, minone_now;
    logic [3:0] hourdec_alm, hourone_alm, mindec_alm, minone_alm;
    logic       sec_level;
    logic [7:0] blink_mask;
    logic       blink_phase;
    logic [6:0] seg, seg_nolz;
    logic       dp_n, dp_n_nolz;
    logic [7:0] an, an_nolz;

    int checks = 0;
    int fails  = 0;
    int pos    = 0;
    logic [6:0] tab [0:7];

    always #5 clk = ~clk;

    seg7_scan_driver #(.DWELL_CYC(DW), .BLANK_CYC(BL), .LZ_BLANK(1)) dut (
        .clk(clk), .rstn(rstn), .en(en),
        .hourdec_now(hourdec_now), .hourone_now(hourone_now),
        .mindec_now(mindec_now), .minone_now(minone_now),
        .hourdec_alm(hourdec_alm), .hourone_alm(hourone_alm),
        .mindec_alm(mindec_alm), .minone_alm(minone_alm),
        .sec_level(sec_level), .blink_mask(blink_mask), .blink_phase(blink_phase),
        .seg(seg), .dp_n(dp_n), .an(an)
    );

    seg7_scan_driver #(.DWELL_CYC(DW), .BLANK_CYC(BL), .LZ_BLANK(0)) dut_nolz (
        .clk(clk), .rstn(rstn), .en(en),
        .hourdec_now(hourdec_now), .hourone_now(hourone_now),
        .mindec_now(mindec_now), .minone_now(minone_now),
        .hourdec_alm(hourdec_alm), .hourone_alm(hourone_alm),
        .mindec_alm(mindec_alm), .minone_alm(minone_alm),
        .sec_level(sec_level), .blink_mask(blink_mask), .blink_phase(blink_phase),
        .seg(seg_nolz), .dp_n(dp_n_nolz), .an(an_nolz)
    );

    // p is the slot-counter position (cycles since release) that the current output reflects
    function automatic logic [7:0] an_for(input int p);
        logic [7:0] one;
        int c;
        int s;
        one = 8'h01;
        c = p % DW;
        s = (p / DW) % 8;
        return (c >= BL) ? ~(one << s) : 8'hFF;
    endfunction

    function automatic logic [6:0] seg_for(input int p);
        return ((p % DW) >= BL) ? tab[(p / DW) % 8] : 7'h7F;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        pos++;
    endtask

    task automatic advance_to(input int target);
        while (pos < target) tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) tick();
        checks++; if (an !== 8'hFF) begin fails++; $display("FAIL reset_an got %h exp ff", an); end
        checks++; if (seg !== 7'h7F) begin fails++; $display("FAIL reset_seg got %b exp 1111111", seg); end
        checks++; if (dp_n !== 1'b1) begin fails++; $display("FAIL reset_dp got %b exp 1", dp_n); end
    endtask

    task automatic test_frame();
        tab = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001,
                7'b0010010, 7'b1000000, 7'b1111000, 7'h7F};
        rstn = 1'b1;
        pos = 0;
        while (pos < 64) begin
            tick();
            checks++; if (an !== an_for(pos - 1)) begin fails++; $display("FAIL frame_an p=%0d got %h exp %h", pos - 1, an, an_for(pos - 1)); end
            checks++; if (seg !== seg_for(pos - 1)) begin fails++; $display("FAIL frame_seg p=%0d got %b exp %b", pos - 1, seg, seg_for(pos - 1)); end
            checks++; if (dp_n !== 1'b1) begin fails++; $display("FAIL frame_dp p=%0d got %b exp 1", pos - 1, dp_n); end
        end
    endtask

    task automatic test_shadow();
        while (pos < 128) begin
            tick();
            checks++; if (an !== an_for(pos - 1)) begin fails++; $display("FAIL shadow_an p=%0d got %h exp %h", pos - 1, an, an_for(pos - 1)); end
            checks++; if (seg !== seg_for(pos - 1)) begin fails++; $display("FAIL shadow_seg p=%0d got %b exp %b", pos - 1, seg, seg_for(pos - 1)); end
            if (pos == 66 || pos == 90) minone_now = 4'd9;
        end
        tab[0] = 7'b0010000;
        while (pos < 192) begin
            tick();
            checks++; if (seg !== seg_for(pos - 1)) begin fails++; $display("FAIL shadow_new_seg p=%0d got %b exp %b", pos - 1, seg, seg_for(pos - 1)); end
        end
    endtask

    task automatic test_colon();
        logic exp_dp;
        sec_level = 1'b1;
        while (pos < 256) begin
            tick();
            exp_dp = ((((pos - 1) / DW) % 8) == 2 && ((pos - 1) % DW) >= BL) ? 1'b0 : 1'b1;
            checks++; if (dp_n !== exp_dp) begin fails++; $display("FAIL colon_on p=%0d got %b exp %b", pos - 1, dp_n, exp_dp); end
            checks++; if (an !== an_for(pos - 1)) begin fails++; $display("FAIL colon_an p=%0d got %h exp %h", pos - 1, an, an_for(pos - 1)); end
        end
        sec_level = 1'b0;
        while (pos < 320) begin
            tick();
            checks++; if (dp_n !== 1'b1) begin fails++; $display("FAIL colon_off p=%0d got %b exp 1", pos - 1, dp_n); end
        end
    endtask

    task automatic test_blink();
        logic [6:0] exp_seg;
        blink_mask = 8'h03;
        blink_phase = 1'b0;
        while (pos < 384) begin
            tick();
            exp_seg = ((((pos - 1) / DW) % 8) <= 1) ? 7'h7F : seg_for(pos - 1);
            checks++; if (seg !== exp_seg) begin fails++; $display("FAIL blink_off p=%0d got %b exp %b", pos - 1, seg, exp_seg); end
            checks++; if (an !== an_for(pos - 1)) begin fails++; $display("FAIL blink_an p=%0d got %h exp %h", pos - 1, an, an_for(pos - 1)); end
        end
        blink_phase = 1'b1;
        while (pos < 448) begin
            tick();
            checks++; if (seg !== seg_for(pos - 1)) begin fails++; $display("FAIL blink_on p=%0d got %b exp %b", pos - 1, seg, seg_for(pos - 1)); end
        end
    endtask

    task automatic test_hour_tens();
        logic [6:0] exp_nolz;
        int s;
        hourdec_now = 4'hB;
        advance_to(512);
        tab[3] = 7'b0111111;
        while (pos < 576) begin
            tick();
            checks++; if (seg !== seg_for(pos - 1)) begin fails++; $display("FAIL dash_seg p=%0d got %b exp %b", pos - 1, seg, seg_for(pos - 1)); end
        end
        hourdec_now = 4'd0;
        advance_to(640);
        tab[3] = 7'h7F;
        while (pos < 704) begin
            tick();
            s = ((pos - 1) / DW) % 8;
            exp_nolz = (((pos - 1) % DW) >= BL && (s == 3 || s == 7)) ? 7'b1000000 : seg_for(pos - 1);
            checks++; if (seg !== seg_for(pos - 1)) begin fails++; $display("FAIL lz_seg p=%0d got %b exp %b", pos - 1, seg, seg_for(pos - 1)); end
            checks++; if (seg_nolz !== exp_nolz) begin fails++; $display("FAIL nolz_seg p=%0d got %b exp %b", pos - 1, seg_nolz, exp_nolz); end
        end
    endtask

    task automatic test_enable();
        int base;
        base = pos;
        advance_to(base + 10);
        en = 1'b0;
        while (pos < base + 15) begin
            tick();
            checks++; if (an !== 8'hFF) begin fails++; $display("FAIL en_off_an p=%0d got %h exp ff", pos - 1, an); end
            checks++; if (seg !== 7'h7F) begin fails++; $display("FAIL en_off_seg p=%0d got %b exp 1111111", pos - 1, seg); end
        end
        en = 1'b1;
        while (pos < base + 24) begin
            tick();
            checks++; if (an !== an_for(pos - 1)) begin fails++; $display("FAIL en_resume_an p=%0d got %h exp %h", pos - 1, an, an_for(pos - 1)); end
        end
    endtask

    task automatic test_reset_mid();
        advance_to(pos + 4);
        rstn = 1'b0;
        tick();
        checks++; if (an !== 8'hFF) begin fails++; $display("FAIL midrst_an got %h exp ff", an); end
        checks++; if (seg !== 7'h7F) begin fails++; $display("FAIL midrst_seg got %b exp 1111111", seg); end
        checks++; if (dp_n !== 1'b1) begin fails++; $display("FAIL midrst_dp got %b exp 1", dp_n); end
        tick();
        rstn = 1'b1;
        pos = 0;
        while (pos < 24) begin
            tick();
            checks++; if (an !== an_for(pos - 1)) begin fails++; $display("FAIL midrst_an_seq p=%0d got %h exp %h", pos - 1, an, an_for(pos - 1)); end
            checks++; if (seg !== seg_for(pos - 1)) begin fails++; $display("FAIL midrst_seg_seq p=%0d got %b exp %b", pos - 1, seg, seg_for(pos - 1)); end
        end
    endtask

    initial begin
        rstn = 1'b0;
        en = 1'b1;
        hourdec_now = 4'd1; hourone_now = 4'd2; mindec_now = 4'd3; minone_now = 4'd4;
        hourdec_alm = 4'd0; hourone_alm = 4'd7; mindec_alm = 4'd0; minone_alm = 4'd5;
        sec_level = 1'b0;
        blink_mask = 8'h00;
        blink_phase = 1'b1;
        test_reset();
        test_frame();
        test_shadow();
        test_colon();
        test_blink();
        test_hour_tens();
        test_enable();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
